// File: rtl/tank_motion_ctrl_if.sv
// rtl/tank_motion_ctrl_if.sv - VGA timing, button and sprite-position signals of the tank controller
interface tank_motion_ctrl_if;
  logic [9:0] Val_Row_In;
  logic [9:0] Val_Col_In;
  logic       Up;
  logic       Down;
  logic       Left;
  logic       Right;
  logic [9:0] Pos_X_Out;
  logic [9:0] Pos_Y_Out;
  logic       Pos_Update_Out;
  logic       Busy_Out;

  modport master (
    output Val_Row_In, Val_Col_In, Up, Down, Left, Right,
    input  Pos_X_Out, Pos_Y_Out, Pos_Update_Out, Busy_Out
  );

  modport slave (
    input  Val_Row_In, Val_Col_In, Up, Down, Left, Right,
    output Pos_X_Out, Pos_Y_Out, Pos_Update_Out, Busy_Out
  );
endinterface

// File: rtl/tank_motion_ctrl.sv
// rtl/tank_motion_ctrl.sv - frame-synchronous tank sprite position controller
// Debounced buttons are sampled once per frame at end of active video; the new origin wraps at the screen edges.
module tank_motion_ctrl #(
  parameter int Pixels_Horiz    = 640,
  parameter int Pixels_Vert     = 480,
  parameter int Sprite_W        = 30,
  parameter int Sprite_H        = 60,
  parameter int Step            = 1,
  parameter int Debounce_Cycles = 50000
) (
  input  logic              Master_Clock_In,
  input  logic              Reset_N_In,
  tank_motion_ctrl_if.slave bus
);

  localparam logic [10:0] MAX_X   = 11'(Pixels_Horiz - Sprite_W);
  localparam logic [10:0] MAX_Y   = 11'(Pixels_Vert - Sprite_H);
  localparam logic [10:0] STEP    = 11'(Step);
  localparam logic [9:0]  X_RST   = 10'((Pixels_Horiz - Sprite_W) / 2);
  localparam logic [9:0]  Y_RST   = 10'((Pixels_Vert - Sprite_H) / 2);
  localparam logic [15:0] DB_LAST = 16'(Debounce_Cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CALC_X,
    S_CALC_Y,
    S_COMMIT
  } state_t;

  // Button vectors are ordered {Up, Down, Left, Right}.
  logic [3:0]  btn_raw;
  logic [3:0]  sync1_q;
  logic [3:0]  sync2_q;
  logic [3:0]  deb_q;
  logic [15:0] cnt_q [4];

  logic        match;
  logic        match_q;
  logic        tick;

  state_t      state_q,  state_d;
  logic [3:0]  snap_q,   snap_d;
  logic [9:0]  next_x_q, next_x_d;
  logic [9:0]  next_y_q, next_y_d;
  logic [9:0]  pos_x_q,  pos_x_d;
  logic [9:0]  pos_y_q,  pos_y_d;
  logic        upd_q,    upd_d;

  assign btn_raw = {bus.Up, bus.Down, bus.Left, bus.Right};

  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 16'd1;
        end
      end
    end
  end

  // match_q resets high so a reset released during the match window does not fire a tick.
  assign match = (bus.Val_Row_In == 10'(Pixels_Horiz)) && (bus.Val_Col_In == 10'(Pixels_Vert));
  assign tick  = match && !match_q;

  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) match_q <= 1'b1;
    else             match_q <= match;
  end

  function automatic logic [9:0] axis_next(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic [10:0] max);
    logic [10:0] sum;
    sum = {1'b0, pos} + STEP;
    if (inc && !dec)      return (sum > max) ? 10'd0 : sum[9:0];
    else if (dec && !inc) return ({1'b0, pos} < STEP) ? max[9:0] : pos - STEP[9:0];
    else                  return pos;
  endfunction

  always_ff @(posedge Master_Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q  <= S_IDLE;
      snap_q   <= '0;
      next_x_q <= '0;
      next_y_q <= '0;
      pos_x_q  <= X_RST;
      pos_y_q  <= Y_RST;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      next_x_q <= next_x_d;
      next_y_q <= next_y_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      upd_q    <= upd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    next_x_d = next_x_q;
    next_y_d = next_y_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    upd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tick) state_d = S_LATCH;
      end
      S_LATCH: begin
        snap_d  = deb_q;
        state_d = S_CALC_X;
      end
      S_CALC_X: begin
        next_x_d = axis_next(pos_x_q, snap_q[0], snap_q[1], MAX_X);
        state_d  = S_CALC_Y;
      end
      S_CALC_Y: begin
        next_y_d = axis_next(pos_y_q, snap_q[2], snap_q[3], MAX_Y);
        state_d  = S_COMMIT;
      end
      S_COMMIT: begin
        pos_x_d = next_x_q;
        pos_y_d = next_y_q;
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Busy also covers the publish cycle so the whole update window is visible downstream.
  assign bus.Pos_X_Out      = pos_x_q;
  assign bus.Pos_Y_Out      = pos_y_q;
  assign bus.Pos_Update_Out = upd_q;
  assign bus.Busy_Out       = (state_q != S_IDLE) || upd_q;

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb/tb_tank_motion_ctrl.sv - self-checking bench for tank_motion_ctrl
module tb_tank_motion_ctrl;
  localparam int DB   = 8;
  localparam int MAXX = 610;
  localparam int MAXY = 420;
  localparam int STEP = 1;

  typedef struct {
    logic [3:0] btn;
    int         frames;
    int         mlen;
    int         exp_x;
    int         exp_y;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tank_motion_ctrl_if bus();

  tank_motion_ctrl #(.Debounce_Cycles(DB)) dut (
    .Master_Clock_In(clk),
    .Reset_N_In     (rst_n),
    .bus            (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         mx, my;
  logic [3:0] cur_btn;
  vec_t       vecs[13];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int move(input int p, input bit inc, input bit dec, input int mx_lim);
    if (inc && !dec) return (p + STEP > mx_lim) ? 0 : p + STEP;
    if (dec && !inc) return (p < STEP) ? mx_lim : p - STEP;
    return p;
  endfunction

  task automatic set_btn(input logic [3:0] b);
    bus.Up    = b[3];
    bus.Down  = b[2];
    bus.Left  = b[1];
    bus.Right = b[0];
    cur_btn   = b;
  endtask

  task automatic settle(input logic [3:0] b);
    @(negedge clk);
    set_btn(b);
    repeat (DB + 4) @(posedge clk);
  endtask

  task automatic run_frame(input int mlen);
    int upd_cnt, upd_at, busy_cnt, nx, ny;
    upd_cnt  = 0;
    upd_at   = -1;
    busy_cnt = 0;
    nx = move(mx, cur_btn[0], cur_btn[1], MAXX);
    ny = move(my, cur_btn[2], cur_btn[3], MAXY);
    @(negedge clk);
    bus.Val_Row_In = 10'd640;
    bus.Val_Col_In = 10'd480;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.Pos_Update_Out) begin
        upd_cnt++;
        upd_at = c;
      end
      if (bus.Busy_Out) busy_cnt++;
      if (c == 3) begin
        check("x_before_commit", int'(bus.Pos_X_Out), mx);
        check("y_before_commit", int'(bus.Pos_Y_Out), my);
      end
      if (c == mlen - 1) begin
        bus.Val_Row_In = 10'd0;
        bus.Val_Col_In = 10'd0;
      end
    end
    check("upd_pulses", upd_cnt, 1);
    check("upd_cycle", upd_at, 4);
    check("busy_cycles", busy_cnt, 5);
    check("x_after", int'(bus.Pos_X_Out), nx);
    check("y_after", int'(bus.Pos_Y_Out), ny);
    mx = nx;
    my = ny;
  endtask

  initial begin
    int upd_seen;
    vecs[0]  = '{4'b0000, 2,   1,  305, 210};
    vecs[1]  = '{4'b0001, 304, 1,  609, 210};
    vecs[2]  = '{4'b0001, 1,   10, 610, 210};
    vecs[3]  = '{4'b0001, 1,   3,  0,   210};
    vecs[4]  = '{4'b0001, 1,   1,  1,   210};
    vecs[5]  = '{4'b0010, 1,   1,  0,   210};
    vecs[6]  = '{4'b0010, 1,   2,  610, 210};
    vecs[7]  = '{4'b1000, 210, 1,  610, 0};
    vecs[8]  = '{4'b1000, 1,   1,  610, 420};
    vecs[9]  = '{4'b0100, 1,   1,  610, 0};
    vecs[10] = '{4'b1111, 3,   10, 610, 0};
    vecs[11] = '{4'b0111, 2,   1,  610, 2};
    vecs[12] = '{4'b1110, 5,   1,  605, 2};

    rst_n = 1'b0;
    bus.Val_Row_In = '0;
    bus.Val_Col_In = '0;
    set_btn(4'b0000);
    mx = 305;
    my = 210;
    repeat (3) @(negedge clk);
    check("rst_x", int'(bus.Pos_X_Out), 305);
    check("rst_y", int'(bus.Pos_Y_Out), 210);
    check("rst_upd", int'(bus.Pos_Update_Out), 0);
    check("rst_busy", int'(bus.Busy_Out), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", int'(bus.Busy_Out), 0);

    for (int v = 0; v < 13; v++) begin
      settle(vecs[v].btn);
      for (int f = 0; f < vecs[v].frames; f++) run_frame(vecs[v].mlen);
      check($sformatf("vec%0d_x", v), int'(bus.Pos_X_Out), vecs[v].exp_x);
      check($sformatf("vec%0d_y", v), int'(bus.Pos_Y_Out), vecs[v].exp_y);
    end

    // Up glitch one cycle short of the debounce window must be ignored.
    settle(4'b0000);
    @(negedge clk);
    bus.Up = 1'b1;
    repeat (DB - 1) @(negedge clk);
    bus.Up = 1'b0;
    repeat (DB + 4) @(negedge clk);
    run_frame(1);
    check("glitch_y", int'(bus.Pos_Y_Out), 2);

    @(negedge clk);
    set_btn(4'b1000);
    repeat (DB + 2) @(negedge clk);
    run_frame(1);
    check("held_up_y", int'(bus.Pos_Y_Out), 1);

    for (int r = 0; r < 20; r++) begin
      settle(4'($urandom_range(0, 15)));
      for (int f = 0; f < int'($urandom_range(1, 4)); f++) run_frame(int'($urandom_range(1, 10)));
    end

    // Reset while in CALC_Y with Right held, released during the match window.
    settle(4'b0001);
    @(negedge clk);
    bus.Val_Row_In = 10'd640;
    bus.Val_Col_In = 10'd480;
    repeat (3) @(posedge clk);
    #1;
    check("mid_seq_busy", int'(bus.Busy_Out), 1);
    rst_n = 1'b0;
    #1;
    check("abort_x", int'(bus.Pos_X_Out), 305);
    check("abort_y", int'(bus.Pos_Y_Out), 210);
    check("abort_upd", int'(bus.Pos_Update_Out), 0);
    check("abort_busy", int'(bus.Busy_Out), 0);
    upd_seen = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (bus.Pos_Update_Out || bus.Busy_Out) upd_seen++;
    end
    bus.Val_Row_In = 10'd0;
    bus.Val_Col_In = 10'd0;
    for (int c = 0; c < DB + 4; c++) begin
      @(posedge clk);
      #1;
      if (bus.Pos_Update_Out || bus.Busy_Out) upd_seen++;
    end
    check("no_update_after_reset", upd_seen, 0);
    check("post_reset_x", int'(bus.Pos_X_Out), 305);
    mx = 305;
    my = 210;
    run_frame(1);
    check("post_reset_frame_x", int'(bus.Pos_X_Out), 306);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
